// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin share of one combinational ALU between two
//               valid/ready requesters, with a per-requester result register.
//               Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins ties).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
);

    // last_grant = 1 means req1 was served last, so req0 wins the next tie
    localparam logic c_LAST_GRANT_RST = 1'b1;

    logic             r_rsp0_valid;
    logic             r_rsp1_valid;
    logic [WIDTH-1:0] r_rsp0_result;
    logic [WIDTH-1:0] r_rsp1_result;
    logic             r_rsp0_zero;
    logic             r_rsp1_zero;
    logic             r_last_grant;

    logic w_elig0;
    logic w_elig1;
    logic w_grant0;
    logic w_grant1;

    // A full slot being drained this cycle may accept a new result
    assign w_elig0 = ~rst & req0_valid & (~r_rsp0_valid | rsp0_ready);
    assign w_elig1 = ~rst & req1_valid & (~r_rsp1_valid | rsp1_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_grant0 = w_elig0;
`else
    assign w_grant0 = w_elig0 & (~w_elig1 | r_last_grant);
`endif
    assign w_grant1 = w_elig1 & ~w_grant0;

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = '0;
        if (w_grant0) begin
            alu_a   = req0_a;
            alu_b   = req0_b;
            alu_sel = req0_op;
        end else if (w_grant1) begin
            alu_a   = req1_a;
            alu_b   = req1_b;
            alu_sel = req1_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp0_valid  <= 1'b0;
            r_rsp1_valid  <= 1'b0;
            r_rsp0_result <= '0;
            r_rsp1_result <= '0;
            r_rsp0_zero   <= 1'b0;
            r_rsp1_zero   <= 1'b0;
            r_last_grant  <= c_LAST_GRANT_RST;
        end else begin
            if (w_grant0) begin
                r_rsp0_result <= alu_out;
                r_rsp0_zero   <= alu_zero;
                r_rsp0_valid  <= 1'b1;
            end else if (r_rsp0_valid && rsp0_ready) begin
                r_rsp0_valid  <= 1'b0;
            end

            if (w_grant1) begin
                r_rsp1_result <= alu_out;
                r_rsp1_zero   <= alu_zero;
                r_rsp1_valid  <= 1'b1;
            end else if (r_rsp1_valid && rsp1_ready) begin
                r_rsp1_valid  <= 1'b0;
            end

            if (w_grant0) begin
                r_last_grant <= 1'b0;
            end else if (w_grant1) begin
                r_last_grant <= 1'b1;
            end
        end
    end

    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp0_result = r_rsp0_result;
    assign rsp1_result = r_rsp1_result;
    assign rsp0_zero   = r_rsp0_zero;
    assign rsp1_zero   = r_rsp1_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Directed self-checking bench for alu_share_arbiter with a
//               behavioural ALU attached to the shared ALU port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;
    localparam int OPW   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
    logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
    logic [OPW-1:0]   req0_op, req1_op, alu_sel;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic             alu_zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_op(req0_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_op(req1_op),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    // Reference ALU: AND, OR, ADD, SUB, signed SLT
    always_comb begin
        alu_out = '0;
        case (alu_sel)
            3'b000: alu_out = alu_a & alu_b;
            3'b001: alu_out = alu_a | alu_b;
            3'b010: alu_out = alu_a + alu_b;
            3'b110: alu_out = alu_a - alu_b;
            3'b111: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; rsp0_ready = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; rsp1_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        req0_valid = 1;
        tick();
        #1;
        total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%0b exp=0", req0_ready); end
        total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b%0b exp=00", rsp0_valid, rsp1_valid); end
        total++; if (rsp0_result !== 32'h0 || rsp1_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h/%h exp=0/0", rsp0_result, rsp1_result); end
        req0_valid = 0;
        rst = 0;
        tick();
        total++; if (alu_sel !== 3'b000 || alu_a !== 32'h0 || alu_b !== 32'h0) begin bad++; $display("FAIL idle_mux got sel=%b a=%h b=%h exp=0", alu_sel, alu_a, alu_b); end
    endtask

    task automatic test_single_op();
        do_reset();
        req0_valid = 1; req0_a = 32'hA; req0_b = 32'h7; req0_op = 3'b010;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL single_ready got=%0b%0b exp=10", req0_ready, req1_ready); end
        total++; if (alu_sel !== 3'b010 || alu_a !== 32'hA) begin bad++; $display("FAIL single_mux got sel=%b a=%h exp sel=010 a=a", alu_sel, alu_a); end
        tick();
        req0_valid = 0;
        total++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h11 || rsp0_zero !== 1'b0) begin bad++; $display("FAIL single_rsp got v=%0b r=%h z=%0b exp v=1 r=11 z=0", rsp0_valid, rsp0_result, rsp0_zero); end
        tick();
        total++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h11) begin bad++; $display("FAIL single_hold got v=%0b r=%h exp v=1 r=11", rsp0_valid, rsp0_result); end
        rsp0_ready = 1;
        tick();
        total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%0b exp=0", rsp0_valid); end
    endtask

    task automatic test_contention();
        logic exp0;
        do_reset();
        rsp0_ready = 1; rsp1_ready = 1;
        req0_valid = 1; req0_a = 32'hA; req0_b = 32'h7; req0_op = 3'b000;
        req1_valid = 1; req1_a = 32'hA; req1_b = 32'h5; req1_op = 3'b001;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp0 = 1'b1;
`else
            exp0 = (i % 2 == 0);
`endif
            #1;
            total++; if (req0_ready !== exp0 || req1_ready !== ~exp0) begin bad++; $display("FAIL contend_grant%0d got=%0b%0b exp=%0b%0b", i, req0_ready, req1_ready, exp0, ~exp0); end
            tick();
            if (exp0) begin
                total++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h2) begin bad++; $display("FAIL contend_rsp0_%0d got v=%0b r=%h exp v=1 r=2", i, rsp0_valid, rsp0_result); end
            end else begin
                total++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'hF || rsp0_valid !== 1'b0) begin bad++; $display("FAIL contend_rsp1_%0d got v1=%0b r=%h v0=%0b exp v1=1 r=f v0=0", i, rsp1_valid, rsp1_result, rsp0_valid); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_back_pressure();
        do_reset();
        req0_valid = 1; req0_a = 32'h1; req0_b = 32'h2; req0_op = 3'b010;
        tick();
        req0_a = 32'h4; req0_b = 32'h4;
        req1_valid = 1; req1_a = 32'h9; req1_b = 32'h2; req1_op = 3'b110; rsp1_ready = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin bad++; $display("FAIL bp_grant%0d got=%0b%0b exp=01", i, req0_ready, req1_ready); end
            tick();
            total++; if (rsp0_result !== 32'h3 || rsp0_valid !== 1'b1 || rsp1_result !== 32'h7) begin bad++; $display("FAIL bp_hold%0d got r0=%h v0=%0b r1=%h exp r0=3 v0=1 r1=7", i, rsp0_result, rsp0_valid, rsp1_result); end
        end
        rsp0_ready = 1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL bp_release got=%0b%0b exp=10", req0_ready, req1_ready); end
        tick();
        total++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h8) begin bad++; $display("FAIL bp_nobubble got v=%0b r=%h exp v=1 r=8", rsp0_valid, rsp0_result); end
        idle_inputs();
    endtask

    task automatic test_zero_flag();
        do_reset();
        req1_valid = 1; req1_a = 32'h5; req1_b = 32'h5; req1_op = 3'b110;
        tick();
        total++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'h0 || rsp1_zero !== 1'b1) begin bad++; $display("FAIL zero_sub got v=%0b r=%h z=%0b exp v=1 r=0 z=1", rsp1_valid, rsp1_result, rsp1_zero); end
        req1_a = 32'h3; req1_b = 32'h9; req1_op = 3'b111; rsp1_ready = 1;
        tick();
        total++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'h1 || rsp1_zero !== 1'b0) begin bad++; $display("FAIL zero_slt got v=%0b r=%h z=%0b exp v=1 r=1 z=0", rsp1_valid, rsp1_result, rsp1_zero); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req1_valid = 1; req1_a = 32'h6; req1_b = 32'h3; req1_op = 3'b001;
        tick();
        req1_valid = 0;
        req0_valid = 1; req0_a = 32'h2; req0_b = 32'h2; req0_op = 3'b010;
        #1;
        total++; if (req0_ready !== 1'b1 || rsp1_valid !== 1'b1) begin bad++; $display("FAIL mid_setup got rdy0=%0b v1=%0b exp 1 1", req0_ready, rsp1_valid); end
        rst = 1;
        #1;
        total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%0b exp=0", req0_ready); end
        tick();
        rst = 0;
        total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp0_result !== 32'h0 || rsp1_result !== 32'h0) begin bad++; $display("FAIL mid_cleared got v=%0b%0b r0=%h r1=%h exp 00 0 0", rsp0_valid, rsp1_valid, rsp0_result, rsp1_result); end
        req1_valid = 1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL mid_tie got=%0b%0b exp=10", req0_ready, req1_ready); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_single_op();
        test_contention();
        test_back_pressure();
        test_zero_flag();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
